rv32i_multicycle_seq: RTL and testbench
=======================================

# rv32i_multicycle_seq

Parametrised multi-cycle sequencer for the RV32I core, the successor to the single-cycle top level. It owns PC, IR and the load-data register, and steps each instruction through fetch, execute, memory and write-back. Instruction and data memory are accessed through req/ready handshakes with arbitrary wait states. It gates the existing datapath (CU, ALU, brancher, reg file) so that state updates happen only at retirement, and adds halt/fault reporting and a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of the retired-instruction counter
- TIMEOUT, 16, maximum cycles a request may wait for ready before a fault (≥2)

- clock  in  1  global clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  store (1) / load (0); valid while dmem_req=1
- dmem_ready  in  1  data access complete; dmem_rdata valid this cycle if load
- dmem_rdata  in  32  raw load data
- cu_store  in  1  from CU, current IR is a store
- cu_load  in  1  from CU, current IR is a load (cu_rdtype = 2'b01)
- cu_rdwrite  in  1  from CU, rd write requested
- PC_next  in  32  from brancher (PC_in of the datapath)
- PC  out  32  architectural PC
- IR  out  32  latched instruction, fed to decode
- mdr  out  32  latched load data, fed to loadselect
- rd_we  out  1  gated register-file write enable
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- halted  out  1  sequencer stopped
- fault  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout

## Operation
- States: IF, EX, MEM, WB, HALT. Reset state IF.
- IF: imem_req=1, imem_addr=PC, wait counter increments each cycle.
  - imem_ready=1: IR<=imem_rdata, counter cleared, go to EX.
  - Counter reaches TIMEOUT-1 without ready: fault<=10, go to HALT.
- EX: one cycle. Decode IR[6:0].
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111. Any other opcode: fault<=01, go to HALT.
  - 1110011 (ECALL/EBREAK): go to HALT with fault=00.
  - cu_load|cu_store: go to MEM. Otherwise go to WB.
- MEM: dmem_req=1, dmem_we=cu_store. Address and store data come from the datapath.
  - dmem_ready=1: if load, mdr<=dmem_rdata; go to WB.
  - Timeout as in IF: fault<=11, go to HALT.
- WB: one cycle.
  - rd_we=cu_rdwrite.
  - PC<=PC_next, retire=1, instret<=instret+1 (wraps modulo 2^CNT_W).
  - Go to IF.
- HALT: all requests low, rd_we=0, PC/IR/instret frozen, halted=1. Exit only by reset.
- rd_we is 0 in every state except WB. A store's memory write happens only in MEM.
- ready inputs are ignored while the matching req is 0.

## Timing
- Reset values: PC=RESET_PC, IR=32'h0000_0013, mdr=0, instret=0, fault=00, halted=0, retire=0, rd_we=0, imem_req=0, dmem_req=0, dmem_we=0.
- Reset assertion clears state and deasserts all outputs immediately, without waiting for a clock edge. After reset is released, the first rising edge drives the design into IF with imem_req=1.
  - Implementation: the state register resets to IF. imem_req is a registered output, set on entry to IF, so it is 0 during reset and 1 from the first edge onward.
- Minimum latency with zero-wait memory: ALU, branch and jump instructions take 3 cycles (IF, EX, WB); load and store take 4.
- Each wait cycle adds 1 cycle. req stays high and addr stays stable until the ready cycle.
- A request is held at most TIMEOUT cycles. ready arriving in cycle TIMEOUT is too late: the fault is taken.
- imem_req and dmem_req are never high in the same cycle.
- retire rises in the WB cycle. The new PC is visible in the following cycle.
- instret updates on the same edge as PC.

## Test plan
- Zero-wait ALU instruction: imem returns 32'h00500093 (addi x1,x0,5) with ready in the same cycle. Required: retire in cycle 3, rd_we=1 only in WB, PC 0→4, instret=1.
- Load with 3 wait states: lw, with dmem_ready 3 cycles after dmem_req. Required: dmem_req held 4 cycles with dmem_we=0, mdr=dmem_rdata, 7-cycle instruction, exactly one retire.
- Store followed by branch-taken PC_next=0x40: store gives rd_we=0 and dmem_we=1. Next retire gives PC=0x40.
- Illegal opcode 32'hFFFFFFFF: required HALT after EX, fault=01, halted=1, no retire, and no requests for the following 20 cycles.
- imem timeout: imem_ready held 0 with TIMEOUT=16. Required: fault=10 after 16 cycles in IF. Then assert reset mid-HALT: outputs return to reset values immediately, and fetch resumes at RESET_PC.
- ECALL 32'h00000073: halted=1 with fault=00. instret equals the count of prior retires.

Source files
------------

// File: rtl/rv32i_multicycle_seq.sv
// rv32i_multicycle_seq
// Multi-cycle instruction sequencer for the RV32I core. It owns PC, IR and
// the load-data register (mdr). Each instruction goes through fetch, execute,
// an optional memory access and write-back. The datapath (CU, ALU, brancher,
// register file) stays combinational; the sequencer gates its state updates
// so that PC, instret and the register-file write happen only at retirement.
//
// Handshake (imem and dmem alike): req is raised and held, and the address
// is kept stable, until the cycle in which ready=1. That cycle completes the
// transfer, and rdata is sampled on the same rising edge. ready is ignored
// while req=0. A request that is still waiting in its TIMEOUT-th cycle
// faults, even if ready arrives in that cycle.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata   instruction fetch port (addr = PC)
//   dmem_req/we/ready/rdata     data port (we: 1 store, 0 load)
//   cu_store/cu_load/cu_rdwrite decode results for the current IR
//   PC_next              next PC from the brancher
//   PC, IR, mdr          architectural PC, latched instruction, load data
//   rd_we                gated register-file write enable (WB only)
//   retire, instret      retirement pulse and retired-instruction counter
//   halted, fault        stop flag; 00 none, 01 illegal, 10 imem/11 dmem timeout
//   dbg_state            current FSM state (IF=0 EX=1 MEM=2 WB=3 HALT=4)
module rv32i_multicycle_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_rdata,
  input  logic             cu_store,
  input  logic             cu_load,
  input  logic             cu_rdwrite,
  input  logic [31:0]      PC_next,
  output logic [31:0]      PC,
  output logic [31:0]      IR,
  output logic [31:0]      mdr,
  output logic             rd_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_EX   = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam int                WCW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0]    WAIT_MAX = WCW'(TIMEOUT - 1);
  localparam logic [31:0]       NOP      = 32'h0000_0013;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t         state, state_next;
  logic           imem_req_q;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     fault_q, fault_next;
  logic           ir_load, mdr_load, wait_clr, wait_inc;
  logic [6:0]     opcode;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111:
        is_legal = 1'b1;
      default:
        is_legal = 1'b0;
    endcase
  endfunction

  assign opcode = IR[6:0];

  always_comb begin
    state_next = state;
    fault_next = fault_q;
    ir_load    = 1'b0;
    mdr_load   = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      S_IF: begin
        // Right after reset the request is not yet up; nothing to count.
        if (imem_req_q) begin
          if (wait_cnt == WAIT_MAX) begin
            fault_next = 2'b10;
            wait_clr   = 1'b1;
            state_next = S_HALT;
          end else if (imem_ready) begin
            ir_load    = 1'b1;
            wait_clr   = 1'b1;
            state_next = S_EX;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      S_EX: begin
        if (opcode == OP_SYSTEM) begin
          state_next = S_HALT;
        end else if (!is_legal(opcode)) begin
          fault_next = 2'b01;
          state_next = S_HALT;
        end else if (cu_load || cu_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (wait_cnt == WAIT_MAX) begin
          fault_next = 2'b11;
          wait_clr   = 1'b1;
          state_next = S_HALT;
        end else if (dmem_ready) begin
          mdr_load   = cu_load;
          wait_clr   = 1'b1;
          state_next = S_WB;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_IF;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IF;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IF;
      imem_req_q <= 1'b0;
      wait_cnt   <= '0;
      fault_q    <= 2'b00;
      PC         <= RESET_PC;
      IR         <= NOP;
      mdr        <= 32'h0;
      instret    <= '0;
    end else begin
      state      <= state_next;
      // Registered fetch request: high for every cycle spent in IF except
      // the first cycle after reset release.
      imem_req_q <= (state_next == S_IF);
      fault_q    <= fault_next;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (ir_load) begin
        IR <= imem_rdata;
      end
      if (mdr_load) begin
        mdr <= dmem_rdata;
      end
      if (state == S_WB) begin
        PC      <= PC_next;
        instret <= instret + 1'b1;
      end
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = PC;
  assign dmem_req  = (state == S_MEM);
  assign dmem_we   = (state == S_MEM) && cu_store;
  assign rd_we     = (state == S_WB) && cu_rdwrite;
  assign retire    = (state == S_WB);
  assign halted    = (state == S_HALT);
  assign fault     = fault_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_rv32i_multicycle_seq.sv
// Testbench for rv32i_multicycle_seq: a table of single instructions with
// per-vector memory wait states, then hand-written halt, fault and reset
// sequences. The bench plays the role of memories, CU and brancher.
module tb_rv32i_multicycle_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 32;
  localparam int          TIMEOUT  = 16;

  // ---------------- clock / reset ----------------
  logic             clock;
  logic             reset;
  logic             imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0]      imem_addr, imem_rdata, dmem_rdata;
  logic             cu_store, cu_load, cu_rdwrite;
  logic [31:0]      PC_next, PC, IR, mdr;
  logic             rd_we, retire, halted;
  logic [CNT_W-1:0] instret;
  logic [1:0]       fault;
  logic [2:0]       dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  rv32i_multicycle_seq #(
    .RESET_PC(RESET_PC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .cu_store(cu_store), .cu_load(cu_load), .cu_rdwrite(cu_rdwrite),
    .PC_next(PC_next), .PC(PC), .IR(IR), .mdr(mdr), .rd_we(rd_we),
    .retire(retire), .instret(instret), .halted(halted), .fault(fault),
    .dbg_state(dbg_state)
  );

  // Stand-in control unit decoding the latched IR.
  assign cu_load    = (IR[6:0] == 7'b0000011);
  assign cu_store   = (IR[6:0] == 7'b0100011);
  assign cu_rdwrite = !((IR[6:0] == 7'b0100011) || (IR[6:0] == 7'b1100011) ||
                        (IR[6:0] == 7'b0001111) || (IR[6:0] == 7'b1110011));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int retire_cnt = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  always @(negedge clock) if (reset && retire) retire_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_PC", PC, RESET_PC);
    chk("rst_IR", IR, 32'h0000_0013);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_fault", {30'h0, fault}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    chk("rst_rd_we", {31'h0, rd_we}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    int          iw;       // imem wait cycles before ready
    int          dw;       // dmem wait cycles before ready
    logic [31:0] pc_next;
    logic [31:0] rdata;    // dmem_rdata in the ready cycle
    int          cycles;   // first IF cycle to WB cycle, inclusive
    logic        rd_we;    // required rd_we in WB
    int          dreq;     // required dmem_req cycles
    logic        we;       // required dmem_we while dmem_req
    logic [31:0] mdr;      // required mdr after retirement
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!imem_req) chk("imem_req_seen", 32'h0, 32'h1);
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    int cycles = 0, iw = 0, dw = 0, dreq = 0;
    int we_bad = 0, addr_bad = 0, rdwe_bad = 0, both_bad = 0;
    logic seen = 1'b0;
    logic rdwe_at_wb = 1'b0;
    PC_next = v.pc_next;
    wait_req();
    for (int k = 0; k < 100; k++) begin
      if (k != 0) @(negedge clock);
      cycles++;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (imem_req) begin
        if (imem_addr !== exp_pc) addr_bad++;
        if (dmem_req) both_bad++;
        if (iw == v.iw) begin
          imem_ready = 1'b1;
          imem_rdata = v.instr;
        end else begin
          iw++;
        end
      end
      if (dmem_req) begin
        dreq++;
        if (dmem_we !== v.we) we_bad++;
        if (dw == v.dw) begin
          dmem_ready = 1'b1;
          dmem_rdata = v.rdata;
        end else begin
          dw++;
        end
      end
      if (rd_we && !retire) rdwe_bad++;
      if (retire) begin
        seen = 1'b1;
        rdwe_at_wb = rd_we;
        break;
      end
    end
    chk({tag, "_retire_seen"}, {31'h0, seen}, 32'h1);
    chk({tag, "_cycles"}, cycles, v.cycles);
    chk({tag, "_rd_we_wb"}, {31'h0, rdwe_at_wb}, {31'h0, v.rd_we});
    chk({tag, "_dreq_cycles"}, dreq, v.dreq);
    chk({tag, "_dmem_we"}, we_bad, 0);
    chk({tag, "_imem_addr"}, addr_bad, 0);
    chk({tag, "_rd_we_outside_wb"}, rdwe_bad, 0);
    chk({tag, "_req_overlap"}, both_bad, 0);
    exp_pc = v.pc_next;
    exp_instret = exp_instret + 1;
    @(negedge clock);
    chk({tag, "_PC_after"}, PC, exp_pc);
    chk({tag, "_instret"}, instret, exp_instret);
    chk({tag, "_mdr"}, mdr, v.mdr);
    chk({tag, "_retire_single"}, {31'h0, retire}, 32'h0);
  endtask

  // Present one instruction with zero wait; returns at the EX-cycle negedge.
  task automatic feed_fetch(input logic [31:0] instr);
    wait_req();
    imem_ready = 1'b1;
    imem_rdata = instr;
    @(negedge clock);
    imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_pc = RESET_PC;
    exp_instret = 0;
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    int bad;
    int r0;
    //          instr         iw dw pc_next       rdata         cyc rdwe dreq we mdr
    vecs[0] = '{32'h00500093, 0, 0, 32'h0000_0004, 32'h0,         3, 1'b1, 0, 1'b0, 32'h0};
    vecs[1] = '{32'h00002103, 0, 3, 32'h0000_0008, 32'hDEADBEEF,  7, 1'b1, 4, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{32'h00102023, 1, 0, 32'h0000_000C, 32'h12345678,  5, 1'b0, 1, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{32'h00000463, 0, 0, 32'h0000_0040, 32'h0,         3, 1'b0, 0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{32'h008000EF, 2, 0, 32'h0000_0048, 32'h0,         5, 1'b1, 0, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{32'h123451B7, 0, 0, 32'h0000_004C, 32'h0,         3, 1'b1, 0, 1'b0, 32'hDEADBEEF};
    vecs[6] = '{32'h0000000F, 0, 0, 32'h0000_0050, 32'h0,         3, 1'b0, 0, 1'b0, 32'hDEADBEEF};

    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    PC_next    = 32'h0;
    reset      = 1'b1;
    @(negedge clock);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i], $sformatf("v%0d", i));
    end
    chk("retire_pulses", retire_cnt, 7);

    // ECALL: halt without fault, instret keeps prior retires.
    r0 = retire_cnt;
    feed_fetch(32'h00000073);
    @(negedge clock);
    chk("ecall_halted", {31'h0, halted}, 32'h1);
    chk("ecall_fault", {30'h0, fault}, 32'h0);
    chk("ecall_state", {29'h0, dbg_state}, 32'h4);
    chk("ecall_instret", instret, 32'd7);
    chk("ecall_no_retire", retire_cnt - r0, 0);

    // Illegal opcode: halt after EX with fault 01, then silence.
    @(negedge clock);
    do_reset();
    r0 = retire_cnt;
    feed_fetch(32'hFFFFFFFF);
    chk("illegal_ex_not_halted", {31'h0, halted}, 32'h0);
    @(negedge clock);
    chk("illegal_halted", {31'h0, halted}, 32'h1);
    chk("illegal_fault", {30'h0, fault}, 32'h1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      if (imem_req || dmem_req || rd_we) bad++;
      @(negedge clock);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    chk("illegal_no_requests", bad, 0);
    chk("illegal_no_retire", retire_cnt - r0, 0);
    chk("illegal_pc_frozen", PC, RESET_PC);

    // imem timeout: ready never comes.
    do_reset();
    wait_req();
    chk("timeout_addr", imem_addr, RESET_PC);
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("timeout_req_cycles", n, TIMEOUT);
    chk("timeout_halted", {31'h0, halted}, 32'h1);
    chk("timeout_fault", {30'h0, fault}, 32'h2);
    @(negedge clock);
    @(negedge clock);

    // Reset mid-HALT clears outputs at once, then fetch restarts at RESET_PC.
    do_reset();
    run_instr(vecs[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
